// File: rtl/serial_parity_checker_pkg.sv
// Shared types and helpers for the serial parity checker.
// Both the RTL and the bench scoreboard use these.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Reduction XOR of a word: 1 when an odd number of bits are set.
    function automatic logic parity_fn(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bit-serial input stream and result strobe of the serial parity checker.
// The source (master) drives in_*; the checker (slave) drives the results.
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8
);

    logic                 in_valid;
    logic                 in_bit;
    logic                 in_sof;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic                 parity_ok;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output in_valid,
        output in_bit,
        output in_sof,
        input  out_valid,
        input  out_data,
        input  parity_ok,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  in_sof,
        output out_valid,
        output out_data,
        output parity_ok,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/serial_parity_checker_xor_accumulator.sv
// One-bit running XOR register. clr restarts the fold, en folds d in;
// with both high the register restarts from d.
module xor_accumulator (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (clr || en) begin
            q <= (clr ? 1'b0 : q) ^ (en & d);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserialises DATA_BITS data bits (LSB first) plus a
// parity bit and strobes the recovered word with parity and framing flags.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = PAR_EVEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_checker_if.slave  sp
);

    localparam int                CNT_W         = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(DATA_BITS - 1);
    localparam logic              PAR_TARGET    = (ODD_PARITY != PAR_EVEN);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 acc;

    logic                 frame_start;
    logic                 data_sample;
    logic                 parity_sample;

    logic                 out_valid_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 parity_ok_q;
    logic                 frame_err_q;
    logic                 busy_q;

    // An in_sof sample always starts a frame, even when it aborts one in flight.
    assign frame_start   = sp.in_valid &  sp.in_sof;
    assign data_sample   = sp.in_valid & ~sp.in_sof & (state == DATA);
    assign parity_sample = sp.in_valid & ~sp.in_sof & (state == PAR);

    xor_accumulator u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .en    (frame_start | data_sample),
        .d     (sp.in_bit),
        .q     (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            parity_ok_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (frame_start) begin
                if (state != IDLE) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= shreg;
                    parity_ok_q <= 1'b0;
                    frame_err_q <= 1'b1;
                end
                shreg  <= DATA_BITS'(sp.in_bit);
                cnt    <= CNT_W'(1);
                state  <= (DATA_BITS == 1) ? PAR : DATA;
                busy_q <= 1'b1;
            end else if (data_sample) begin
                shreg <= shreg | (DATA_BITS'(sp.in_bit) << cnt);
                cnt   <= cnt + 1'b1;
                if (cnt == LAST_DATA_IDX) begin
                    state <= PAR;
                end
            end else if (parity_sample) begin
                out_valid_q <= 1'b1;
                out_data_q  <= shreg;
                parity_ok_q <= ((acc ^ sp.in_bit) == PAR_TARGET);
                frame_err_q <= 1'b0;
                state       <= IDLE;
                cnt         <= '0;
                busy_q      <= 1'b0;
            end
        end
    end

    assign sp.out_valid = out_valid_q;
    assign sp.out_data  = out_data_q;
    assign sp.parity_ok = parity_ok_q;
    assign sp.frame_err = frame_err_q;
    assign sp.busy      = busy_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even-mode and an odd-mode instance see the
// same bit stream; each has its own scoreboard queue of expected strobes.
module tb_serial_parity_checker;
    import parity_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_parity_checker_if #(.DATA_BITS(8)) sp_even ();
    serial_parity_checker_if #(.DATA_BITS(8)) sp_odd ();

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(PAR_EVEN)) dut_even (
        .clk   (clk),
        .rst_n (rst_n),
        .sp    (sp_even)
    );

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(PAR_ODD)) dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .sp    (sp_odd)
    );

    typedef struct {
        logic [7:0] data;
        logic       ok;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       gap;
        logic       ok_even;
        logic       ok_odd;
    } vec_t;

    exp_t q_even[$];
    exp_t q_odd[$];
    vec_t vecs[6];

    int checks      = 0;
    int fails       = 0;
    int cyc         = 0;
    int last_strobe = 0;
    int prev_strobe = 0;
    logic prev_ov_even = 1'b0;
    logic prev_ov_odd  = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one sample to both instances for exactly one rising edge.
    task automatic drive(input logic v, input logic b, input logic s);
        sp_even.in_valid = v;
        sp_even.in_bit   = b;
        sp_even.in_sof   = s;
        sp_odd.in_valid  = v;
        sp_odd.in_bit    = b;
        sp_odd.in_sof    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic ok_e, input logic ok_o, input logic err);
        exp_t e;
        e.data = d;
        e.err  = err;
        e.ok   = ok_e;
        q_even.push_back(e);
        e.ok   = ok_o;
        q_odd.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic gap,
                              input logic ok_e, input logic ok_o);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, d[i], (i == 0));
            if (i == 0) check("busy_rise", sp_even.busy, 1);
            if (gap) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end
        push_exp(d, ok_e, ok_o, 1'b0);
        drive(1'b1, par, 1'b0);
        @(negedge clk);
        #1;
        check("strobe_latency_even", sp_even.out_valid, 1);
        check("strobe_latency_odd", sp_odd.out_valid, 1);
        check("busy_fall", sp_even.busy, 0);
    endtask

    always @(negedge clk) begin : mon_even
        exp_t e;
        if (sp_even.out_valid) begin
            check("even_strobe_width", prev_ov_even, 0);
            prev_strobe = last_strobe;
            last_strobe = cyc;
            if (q_even.size() == 0) begin
                check("even_unexpected_strobe", sp_even.out_valid, 0);
            end else begin
                e = q_even.pop_front();
                check("even_out_data", sp_even.out_data, e.data);
                check("even_parity_ok", sp_even.parity_ok, e.ok);
                check("even_frame_err", sp_even.frame_err, e.err);
            end
        end
        prev_ov_even = sp_even.out_valid;
    end

    always @(negedge clk) begin : mon_odd
        exp_t e;
        if (sp_odd.out_valid) begin
            check("odd_strobe_width", prev_ov_odd, 0);
            if (q_odd.size() == 0) begin
                check("odd_unexpected_strobe", sp_odd.out_valid, 0);
            end else begin
                e = q_odd.pop_front();
                check("odd_out_data", sp_odd.out_data, e.data);
                check("odd_parity_ok", sp_odd.parity_ok, e.ok);
                check("odd_frame_err", sp_odd.frame_err, e.err);
            end
        end
        prev_ov_odd = sp_odd.out_valid;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] rd;
        logic       rp;
        logic       rg;

        vecs[0] = '{data: 8'hA5, par: 1'b0, gap: 1'b0, ok_even: 1'b1, ok_odd: 1'b0};
        vecs[1] = '{data: 8'hA5, par: 1'b1, gap: 1'b0, ok_even: 1'b0, ok_odd: 1'b1};
        vecs[2] = '{data: 8'h01, par: 1'b0, gap: 1'b1, ok_even: 1'b0, ok_odd: 1'b1};
        vecs[3] = '{data: 8'h00, par: 1'b0, gap: 1'b0, ok_even: 1'b1, ok_odd: 1'b0};
        vecs[4] = '{data: 8'h7E, par: 1'b1, gap: 1'b1, ok_even: 1'b0, ok_odd: 1'b1};
        vecs[5] = '{data: 8'h3C, par: 1'b0, gap: 1'b0, ok_even: 1'b1, ok_odd: 1'b0};

        sp_even.in_valid = 1'b0; sp_even.in_bit = 1'b0; sp_even.in_sof = 1'b0;
        sp_odd.in_valid  = 1'b0; sp_odd.in_bit  = 1'b0; sp_odd.in_sof  = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_out_valid", sp_even.out_valid, 0);
        check("reset_out_data", sp_even.out_data, 0);
        check("reset_parity_ok", sp_odd.parity_ok, 0);
        check("reset_frame_err", sp_even.frame_err, 0);
        check("reset_busy", sp_odd.busy, 0);
        rst_n = 1'b1;

        // Valid samples without in_sof while idle must be ignored.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("idle_ignore_busy", sp_even.busy, 0);
        drive(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].gap, vecs[i].ok_even, vecs[i].ok_odd);
        end

        // Back-to-back frames, no idle cycle between them.
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b_spacing", last_strobe - prev_strobe, 9);
        drive(1'b0, 1'b0, 1'b0);

        // Abort after 3 bits (1,1,0); the new in_sof starts 0x3C.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        push_exp(8'h03, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Reset after 4 bits of a frame: outputs clear immediately, no strobe.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        sp_even.in_valid = 1'b0;
        sp_odd.in_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", sp_even.busy, 0);
        check("midreset_out_data", sp_even.out_data, 0);
        check("midreset_parity_ok", sp_even.parity_ok, 0);
        check("midreset_odd_out_data", sp_odd.out_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        check("midreset_no_strobe_q", q_even.size(), 0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random frames, expectations from the package parity helper.
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            send_frame(rd, rp, rg,
                       (parity_fn({24'b0, rd}) ^ rp) == 1'b0,
                       (parity_fn({24'b0, rd}) ^ rp) == 1'b1);
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("final_queue_even", q_even.size(), 0);
        check("final_queue_odd", q_odd.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
